// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data port: access-size codes, FSM
// states and the lane helpers used to build byte enables and store data.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Undefined size codes are refused just like a misaligned access.
  function automatic logic access_ok(input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    case (funct3)
      F3_B, F3_BU: access_ok = 1'b1;
      F3_H, F3_HU: access_ok = ~addr_lo[0];
      F3_W:        access_ok = (addr_lo == 2'b00);
      default:     access_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    case (funct3)
      F3_B, F3_BU: lane_be = 4'b0001 << addr_lo;
      F3_H, F3_HU: lane_be = 4'b0011 << addr_lo;
      default:     lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0]  funct3,
                                             input logic [31:0] wdata);
    case (funct3)
      F3_B, F3_BU: lane_wdata = {4{wdata[7:0]}};
      F3_H, F3_HU: lane_wdata = {2{wdata[15:0]}};
      default:     lane_wdata = wdata;
    endcase
  endfunction

endpackage

// File: rtl/dmem_port_if.sv
// External data-bus bundle: req/ack handshake plus word address, lanes and data.
interface dmem_port_if;
  logic        bus_req;
  logic        bus_we;
  logic [29:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic        bus_err;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_err, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_err, bus_rdata
  );
endinterface

// File: rtl/dmem_port_load_align.sv
// Combinational load alignment: picks the addressed byte/half out of a word
// and sign- or zero-extends it. Kept standalone for reuse on the fetch side.
module load_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = word[{addr_lo, 3'b000} +: 8];
  assign half_v = word[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: result gets a value on every path (default arm included) so no latch is inferred.
    case (funct3)
      F3_B:    result = {{24{byte_v[7]}}, byte_v};
      F3_BU:   result = {24'h0, byte_v};
      F3_H:    result = {{16{half_v[15]}}, half_v};
      F3_HU:   result = {16'h0, half_v};
      F3_W:    result = word;
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_port.sv
// MEM-stage data-memory port: lane alignment, one req/ack bus transaction per
// access with timeout, and the MEM_valid stall signal for the hazard unit.
module dmem_port
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_read,
  input  logic               req_write,
  input  logic [2:0]         req_funct3,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               MEM_valid,
  output logic [31:0]        rdata,
  output logic               misaligned,
  output logic               err,
  dmem_port_if.master        bus
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_e      state;
  logic [15:0] cnt;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic [31:0] load_word;

  logic access;
  logic ok;
  logic start;

  assign access = req_read | req_write;
  assign ok     = access_ok(req_funct3, req_addr[1:0]);
  assign start  = (state == ST_IDLE) && access && ok;

  // The stall must be combinational so EXEC freezes in the same cycle the
  // access is first seen; under reset the pipeline is never stalled.
  assign MEM_valid  = ~rst_n | ~(start | (state == ST_WAIT));
  assign misaligned = rst_n & (state == ST_IDLE) & access & ~ok;

  load_align u_load_align (
    .funct3  (f3_q),
    .addr_lo (lo_q),
    .word    (bus.bus_rdata),
    .result  (load_word)
  );

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      f3_q          <= '0;
      lo_q          <= '0;
      rdata         <= '0;
      err           <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= '0;
      bus.bus_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state         <= ST_WAIT;
            cnt           <= '0;
            f3_q          <= req_funct3;
            lo_q          <= req_addr[1:0];
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= req_write;
            bus.bus_addr  <= req_addr[31:2];
            bus.bus_be    <= lane_be(req_funct3, req_addr[1:0]);
            bus.bus_wdata <= lane_wdata(req_funct3, req_wdata);
          end
        end

        ST_WAIT: begin
          if (bus.bus_ack) begin
            state       <= ST_RESP;
            cnt         <= '0;
            bus.bus_req <= 1'b0;
            rdata       <= load_word;
            err         <= bus.bus_err;
          end else if (cnt == CNT_LAST) begin
            // The counter would reach TIMEOUT on this edge: abort.
            state       <= ST_RESP;
            cnt         <= '0;
            bus.bus_req <= 1'b0;
            rdata       <= '0;
            err         <= 1'b1;
          end else if (cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
          end
        end

        ST_RESP: begin
          // Result is presented for exactly this cycle; the held request is
          // consumed and not re-issued.
          state <= ST_IDLE;
          rdata <= '0;
          err   <= 1'b0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port.sv
// Randomised and directed bench for dmem_port with a behavioural reference model.
module tb_dmem_port;
  import dmem_pkg::*;

  localparam int TO_MAIN  = 16;
  localparam int TO_SHORT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_read, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        sel;

  int n_vec = 0;
  int n_bad = 0;

  dmem_port_if bus_m ();
  dmem_port_if bus_t ();

  logic        m_rr, m_rw, t_rr, t_rw;
  logic        m_valid, m_mis, m_err, t_valid, t_mis, t_err;
  logic [31:0] m_rdata, t_rdata;

  assign m_rr = req_read  & ~sel;
  assign m_rw = req_write & ~sel;
  assign t_rr = req_read  & sel;
  assign t_rw = req_write & sel;

  dmem_port #(.TIMEOUT(TO_MAIN)) u_main (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_read   (m_rr),
    .req_write  (m_rw),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .MEM_valid  (m_valid),
    .rdata      (m_rdata),
    .misaligned (m_mis),
    .err        (m_err),
    .bus        (bus_m)
  );

  dmem_port #(.TIMEOUT(TO_SHORT)) u_short (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_read   (t_rr),
    .req_write  (t_rw),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .MEM_valid  (t_valid),
    .rdata      (t_rdata),
    .misaligned (t_mis),
    .err        (t_err),
    .bus        (bus_t)
  );

  // Observed view of whichever instance is under test.
  logic        v_valid, v_mis, v_err, v_req, v_we;
  logic [31:0] v_rdata, v_wdata;
  logic [29:0] v_addr;
  logic [3:0]  v_be;

  assign v_valid = sel ? t_valid : m_valid;
  assign v_mis   = sel ? t_mis   : m_mis;
  assign v_err   = sel ? t_err   : m_err;
  assign v_rdata = sel ? t_rdata : m_rdata;
  assign v_req   = sel ? bus_t.bus_req   : bus_m.bus_req;
  assign v_we    = sel ? bus_t.bus_we    : bus_m.bus_we;
  assign v_addr  = sel ? bus_t.bus_addr  : bus_m.bus_addr;
  assign v_be    = sel ? bus_t.bus_be    : bus_m.bus_be;
  assign v_wdata = sel ? bus_t.bus_wdata : bus_m.bus_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic set_ack(input logic ack, input logic berr, input logic [31:0] word);
    bus_m.bus_ack   = ack & ~sel;
    bus_t.bus_ack   = ack & sel;
    bus_m.bus_err   = berr;
    bus_t.bus_err   = berr;
    bus_m.bus_rdata = word;
    bus_t.bus_rdata = word;
  endtask

  // ---------------- reference model ----------------
  function automatic int ref_size(input logic [2:0] f3);
    if (f3 == F3_B || f3 == F3_BU) return 1;
    if (f3 == F3_H || f3 == F3_HU) return 2;
    if (f3 == F3_W) return 4;
    return 0;
  endfunction

  function automatic bit ref_ok(input logic [2:0] f3, input logic [31:0] addr);
    int n = ref_size(f3);
    if (n == 0) return 0;
    return (addr % n) == 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
    int n = ref_size(f3);
    int v = ((1 << n) - 1) << (addr % 4);
    return 4'(v);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] w);
    int n = ref_size(f3);
    if (n == 1) return (w % 256) * 32'h0101_0101;
    if (n == 2) return (w % 65536) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
    int     n    = ref_size(f3);
    longint bits = 8 * n;
    longint v;
    if (n == 4) return word;
    v = (longint'(word) >> (8 * (addr % 4))) % (longint'(1) << bits);
    if ((f3 == F3_B || f3 == F3_H) && v >= (longint'(1) << (bits - 1)))
      v = v - (longint'(1) << bits);
    return 32'(v);
  endfunction

  // ---------------- one access ----------------
  task automatic run_access(input string tag, input bit rd, input bit wr,
                            input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] word,
                            input int ack_dly, input bit berr);
    bit ok  = ref_ok(f3, addr);
    int tmo = sel ? TO_SHORT : TO_MAIN;
    int exp_wait;
    int stalls = 1;
    bit got_resp = 0;

    @(posedge clk); #1;
    req_read = rd; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(negedge clk);

    if (!ok) begin
      check({tag, "/mis_valid"}, v_valid, 1);
      check({tag, "/mis_flag"},  v_mis,   1);
      check({tag, "/mis_rdata"}, v_rdata, 0);
      check({tag, "/mis_noreq"}, v_req,   0);
      @(posedge clk); #1;
      req_read = 0; req_write = 0;
      @(negedge clk);
      check({tag, "/mis_pulse"}, v_mis, 0);
      check({tag, "/mis_noreq2"}, v_req, 0);
      return;
    end

    check({tag, "/c0_valid"}, v_valid, 0);
    check({tag, "/c0_mis"},   v_mis,   0);

    for (int k = 0; k < 300 && !got_resp; k++) begin
      @(posedge clk); #1;
      set_ack(k == ack_dly, berr && (k == ack_dly), word);
      @(negedge clk);
      if (v_valid) begin
        got_resp = 1;
      end else begin
        stalls++;
        check({tag, "/wait_req"},  v_req,  1);
        check({tag, "/wait_addr"}, v_addr, addr[31:2]);
        check({tag, "/wait_be"},   v_be,   ref_be(f3, addr));
        check({tag, "/wait_we"},   v_we,   wr);
        if (wr) check({tag, "/wait_wdata"}, v_wdata, ref_wdata(f3, wdata));
      end
    end

    exp_wait = (ack_dly < tmo) ? ack_dly + 1 : tmo;
    check({tag, "/resp_seen"}, got_resp, 1);
    check({tag, "/stall_cycles"}, stalls, 1 + exp_wait);
    check({tag, "/resp_noreq"}, v_req, 0);
    if (ack_dly < tmo) begin
      check({tag, "/resp_rdata"}, v_rdata, ref_load(f3, addr, word));
      check({tag, "/resp_err"},   v_err,   berr);
    end else begin
      check({tag, "/tmo_rdata"}, v_rdata, 0);
      check({tag, "/tmo_err"},   v_err,   1);
    end

    // Request withdrawn; a stray ack in IDLE must have no effect.
    @(posedge clk); #1;
    req_read = 0; req_write = 0;
    set_ack(1, 1, 32'hDEAD_BEEF);
    @(negedge clk);
    check({tag, "/idle_valid"}, v_valid, 1);
    check({tag, "/idle_err"},   v_err,   0);
    check({tag, "/idle_rdata"}, v_rdata, 0);
    @(posedge clk); #1;
    set_ack(0, 0, 32'h0);
    @(negedge clk);
    check({tag, "/stray_noreq"}, v_req, 0);
    check({tag, "/stray_valid"}, v_valid, 1);
  endtask

  initial begin
    sel = 0;
    req_read = 0; req_write = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    set_ack(0, 0, 32'h0);

    #12;
    check("rst/valid", v_valid, 1);
    check("rst/req",   v_req,   0);
    check("rst/we",    v_we,    0);
    check("rst/addr",  v_addr,  0);
    check("rst/be",    v_be,    0);
    check("rst/wdata", v_wdata, 0);
    check("rst/rdata", v_rdata, 0);
    check("rst/err",   v_err,   0);
    check("rst/mis",   v_mis,   0);
    #11 rst_n = 1;

    // Directed cases on the long-timeout instance.
    run_access("lb",    1, 0, F3_B,  32'h103, 0, 32'h80FF_1234, 0, 0);
    run_access("lbu",   1, 0, F3_BU, 32'h103, 0, 32'h80FF_1234, 0, 0);
    run_access("lh",    1, 0, F3_H,  32'h102, 0, 32'h80FF_1234, 4, 0);
    run_access("lhu",   1, 0, F3_HU, 32'h100, 0, 32'h80FF_9234, 1, 0);
    run_access("sb",    0, 1, F3_B,  32'h101, 32'h0000_00AB, 32'h0, 1, 0);
    run_access("sh",    0, 1, F3_H,  32'h102, 32'h0000_1234, 32'h0, 2, 0);
    run_access("sw_rw", 1, 1, F3_W,  32'h200, 32'hCAFE_F00D, 32'h1111_2222, 0, 0);
    run_access("lw_mis", 1, 0, F3_W, 32'h102, 0, 32'h0, 0, 0);
    run_access("sh_mis", 0, 1, F3_H, 32'h103, 32'h55, 32'h0, 0, 0);
    run_access("f3_bad", 1, 0, 3'b011, 32'h100, 0, 32'h0, 0, 0);
    run_access("berr",  1, 0, F3_W,  32'h100, 0, 32'h1234_5678, 2, 1);

    // Timeout boundary on the TIMEOUT=4 instance.
    sel = 1;
    run_access("tmo_none", 1, 0, F3_W, 32'h300, 0, 32'h0, 999, 0);
    run_access("tmo_last", 1, 0, F3_W, 32'h300, 0, 32'hA5A5_5A5A, TO_SHORT - 1, 0);
    run_access("tmo_late", 0, 1, F3_B, 32'h301, 32'h7E, 32'h0, TO_SHORT, 0);
    sel = 0;

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f3   = 3'($urandom_range(7));
      logic [31:0] addr = $urandom;
      int          op   = $urandom_range(1, 3);
      if ($urandom_range(1) == 1) addr[1:0] = 2'b00;
      run_access("rand", op[0], op[1], f3, addr, $urandom, $urandom,
                 $urandom_range(7), ($urandom_range(7) == 0));
    end

    // Reset in the middle of WAIT.
    @(posedge clk); #1;
    req_read = 1; req_write = 0; req_funct3 = F3_W; req_addr = 32'h400;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstw/req_before", v_req, 1);
    #2 rst_n = 0;
    #1;
    check("rstw/req_drop",  v_req,   0);
    check("rstw/valid",     v_valid, 1);
    req_read = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    set_ack(1, 0, 32'h9999_9999);
    @(negedge clk);
    check("rstw/late_valid", v_valid, 1);
    check("rstw/late_req",   v_req,   0);
    @(posedge clk); #1;
    set_ack(0, 0, 32'h0);
    @(negedge clk);
    check("rstw/no_resp_rdata", v_rdata, 0);
    check("rstw/no_resp_err",   v_err,   0);
    check("rstw/valid_after",   v_valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
